// File: rtl/axi_read_burst_credit_ctrl_if.sv
// AR handshake, R-buffer pop and credit status bundle for axi_read_burst_credit_ctrl.
// The controller takes the slave modport; the surrounding logic (or a bench) takes master.
interface axi_read_burst_credit_ctrl_if #(
    parameter int BUF_DEPTH = 16,
    parameter int MAX_TXNS  = 8
);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int TXN_W = $clog2(MAX_TXNS + 1);

    logic             slv_ar_valid;
    logic [7:0]       slv_ar_len;
    logic             slv_ar_ready;
    logic             mst_ar_valid;
    logic             mst_ar_ready;
    logic             r_pop;
    logic             r_pop_last;
    logic [CNT_W-1:0] free;
    logic [TXN_W-1:0] txns;
    logic             oversize;

    modport master (
        output slv_ar_valid, slv_ar_len, mst_ar_ready, r_pop, r_pop_last,
        input  slv_ar_ready, mst_ar_valid, free, txns, oversize
    );

    modport slave (
        input  slv_ar_valid, slv_ar_len, mst_ar_ready, r_pop, r_pop_last,
        output slv_ar_ready, mst_ar_valid, free, txns, oversize
    );
endinterface

// File: rtl/axi_read_burst_credit_ctrl.sv
// AR admission controller: a read burst is forwarded only after buffer space for all
// of its beats is reserved, so the R buffer never back-pressures the downstream R channel.
module axi_read_burst_credit_ctrl #(
    parameter int BUF_DEPTH = 16,
    parameter int MAX_TXNS  = 8,
    localparam int CNT_W    = $clog2(BUF_DEPTH + 1),
    localparam int TXN_W    = $clog2(MAX_TXNS + 1)
) (
    input logic                         clk,
    input logic                         rst_n,
    axi_read_burst_credit_ctrl_if.slave bus
);
    if (BUF_DEPTH < 1) begin : g_bad_depth
        $error("axi_read_burst_credit_ctrl: BUF_DEPTH must be >= 1");
    end
    if (MAX_TXNS < 1) begin : g_bad_txns
        $error("axi_read_burst_credit_ctrl: MAX_TXNS must be >= 1");
    end

    localparam logic [CNT_W-1:0] FULL    = CNT_W'(BUF_DEPTH);
    localparam logic [TXN_W-1:0] TXN_MAX = TXN_W'(MAX_TXNS);

    typedef enum logic {IDLE, ISSUE} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] free_q, free_d;
    logic [TXN_W-1:0] txns_q, txns_d;
    logic             ovs_q, ovs_d;

    logic [8:0]       need;
    logic             need_ovs;
    logic             fits;
    logic             admit_norm;
    logic             admit_ovs;
    logic             pop_last;

    assign need     = {1'b0, bus.slv_ar_len} + 9'd1;
    assign need_ovs = 32'(need) > 32'(BUF_DEPTH);
    assign fits     = 32'(need) <= 32'(free_q);
    assign pop_last = bus.r_pop & bus.r_pop_last;

    assign admit_norm = (state_q == IDLE) & bus.slv_ar_valid & ~ovs_q & (txns_q < TXN_MAX)
                      & fits & ~need_ovs;
    assign admit_ovs  = (state_q == IDLE) & bus.slv_ar_valid & need_ovs & ~ovs_q
                      & (txns_q == '0) & (free_q == FULL);

    always_comb begin
        state_d          = state_q;
        free_d           = free_q;
        txns_d           = txns_q;
        ovs_d            = ovs_q;
        bus.mst_ar_valid = 1'b0;
        bus.slv_ar_ready = 1'b0;

        // An oversize burst owns the whole buffer; only its final beat releases it.
        if (ovs_q) begin
            if (pop_last) begin
                free_d = FULL;
                txns_d = '0;
                ovs_d  = 1'b0;
            end
        end else if (admit_ovs) begin
            free_d = '0;
            txns_d = TXN_W'(1);
            ovs_d  = 1'b1;
        end else begin
            free_d = free_q - (admit_norm ? CNT_W'(need) : '0) + CNT_W'(bus.r_pop);
            txns_d = txns_q + TXN_W'(admit_norm) - TXN_W'(pop_last);
        end

        unique case (state_q)
            IDLE: begin
                if (admit_norm || admit_ovs) state_d = ISSUE;
            end
            ISSUE: begin
                bus.mst_ar_valid = 1'b1;
                bus.slv_ar_ready = bus.mst_ar_ready;
                if (bus.mst_ar_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            free_q  <= FULL;
            txns_q  <= '0;
            ovs_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            free_q  <= free_d;
            txns_q  <= txns_d;
            ovs_q   <= ovs_d;
        end
    end

    assign bus.free     = free_q;
    assign bus.txns     = txns_q;
    assign bus.oversize = ovs_q;

    a_pop_needs_txn: assert property (@(posedge clk) disable iff (!rst_n)
        bus.r_pop |-> txns_q != '0);
    a_pop_within_reservation: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.r_pop && !ovs_q) |-> free_q != FULL);
    a_free_bound: assert property (@(posedge clk) disable iff (!rst_n) free_q <= FULL);
    a_txns_bound: assert property (@(posedge clk) disable iff (!rst_n) txns_q <= TXN_MAX);
endmodule

// File: tb/tb_axi_read_burst_credit_ctrl.sv
// Randomized bench for axi_read_burst_credit_ctrl against a burst-level credit model
// with an in-order buffer that returns beats only for bursts already issued downstream.
module tb_axi_read_burst_credit_ctrl;
    localparam int DEPTH = 16;
    localparam int MAXT  = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_read_burst_credit_ctrl_if #(.BUF_DEPTH(DEPTH), .MAX_TXNS(MAXT)) bus ();

    axi_read_burst_credit_ctrl #(.BUF_DEPTH(DEPTH), .MAX_TXNS(MAXT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // reference state
    int  m_free     = DEPTH;
    int  m_txns     = 0;
    bit  m_ovs      = 1'b0;
    bit  m_issuing  = 1'b0;
    int  m_pend     = 0;
    bit  m_known    = 1'b0;
    int  beats_q[$];

    // upstream AR held until its handshake
    bit       ar_valid = 1'b0;
    bit [7:0] ar_len   = '0;

    int p_valid, p_ready, p_pop, len_mode;

    task automatic check(input string tag, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    endtask

    function automatic bit [7:0] pick_len();
        int r;
        r = int'($urandom_range(0, 9));
        case (len_mode)
            0: return 8'($urandom_range(0, 3));
            1: begin
                if (r == 0) return 8'd15;
                if (r == 1) return 8'd16;
                return 8'($urandom_range(0, 15));
            end
            default: begin
                if (r < 3) return 8'($urandom_range(16, 40));
                return 8'($urandom_range(0, 3));
            end
        endcase
    endfunction

    task automatic step(input bit do_rst);
        bit rdy, pop, last, os, admit, hs, plast;
        int need;
        @(negedge clk);
        rst_n = !do_rst;
        if (!ar_valid && $urandom_range(0, 99) < p_valid) begin
            ar_valid = 1'b1;
            ar_len   = pick_len();
        end
        rdy  = $urandom_range(0, 99) < p_ready;
        pop  = (beats_q.size() > 0) && ($urandom_range(0, 99) < p_pop);
        last = pop ? (beats_q[0] == 1) : 1'($urandom_range(0, 1));
        bus.slv_ar_valid = ar_valid;
        bus.slv_ar_len   = ar_len;
        bus.mst_ar_ready = rdy;
        bus.r_pop        = pop;
        bus.r_pop_last   = last;
        #1;
        if (m_known) begin
            check("mst_ar_valid", 32'(bus.mst_ar_valid), 32'(m_issuing));
            check("slv_ar_ready", 32'(bus.slv_ar_ready), 32'(m_issuing && rdy));
            check("free", 32'(bus.free), m_free);
            check("txns", 32'(bus.txns), m_txns);
            check("oversize", 32'(bus.oversize), 32'(m_ovs));
        end
        if (do_rst) begin
            m_free = DEPTH; m_txns = 0; m_ovs = 1'b0; m_issuing = 1'b0;
            beats_q.delete();
            ar_valid = 1'b0;
            m_known  = 1'b1;
        end else begin
            need  = int'(ar_len) + 1;
            os    = need > DEPTH;
            plast = pop && last;
            hs    = m_issuing && rdy;
            admit = !m_issuing && ar_valid && !m_ovs &&
                    (os ? (m_txns == 0 && m_free == DEPTH) : (m_txns < MAXT && need <= m_free));
            if (pop) begin
                beats_q[0] = beats_q[0] - 1;
                if (beats_q[0] == 0) void'(beats_q.pop_front());
            end
            if (hs) begin
                beats_q.push_back(m_pend);
                m_issuing = 1'b0;
                ar_valid  = 1'b0;
            end
            if (m_ovs) begin
                if (plast) begin m_free = DEPTH; m_txns = 0; m_ovs = 1'b0; end
            end else if (admit && os) begin
                m_free = 0; m_txns = 1; m_ovs = 1'b1;
            end else begin
                m_free = m_free + int'(pop) - (admit ? need : 0);
                m_txns = m_txns + int'(admit) - int'(plast);
            end
            if (admit) begin
                m_issuing = 1'b1;
                m_pend    = need;
            end
        end
        @(posedge clk);
    endtask

    task automatic run_phase(input int cycles, input int pv, input int pr, input int pp,
                             input int lm);
        p_valid = pv; p_ready = pr; p_pop = pp; len_mode = lm;
        step(1'b1);
        for (int i = 0; i < cycles; i++) step($urandom_range(0, 299) == 0);
    endtask

    initial begin
        bus.slv_ar_valid = 1'b0;
        bus.slv_ar_len   = '0;
        bus.mst_ar_ready = 1'b0;
        bus.r_pop        = 1'b0;
        bus.r_pop_last   = 1'b0;
        run_phase(600, 70, 70, 60, 0);   // short bursts, mixed traffic
        run_phase(600, 80, 60, 30, 1);   // credit-starved, len 15/16 boundary
        run_phase(900, 70, 70, 80, 2);   // oversize bursts interleaved
        run_phase(400, 90, 80, 15, 0);   // slow drain, txn limit reached
        run_phase(400, 90, 10, 50, 1);   // downstream stalls
        run_phase(400, 100, 100, 100, 0);
        run_phase(300, 100, 100, 100, 2);
        step(1'b0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/axi_read_burst_credit_ctrl.md
Name: axi_read_burst_credit_ctrl

Overview:
- AR admission controller for the R-channel burst buffer.
- Admits a read burst downstream only once buffer space for every beat of that burst has been reserved. The buffer therefore never back-pressures the downstream R channel.
- Sits on the AR path in front of the buffer. Credits are returned as beats leave the buffer on the upstream side.
- All AR payload fields except len pass outside this block. The block only gates valid/ready.

Parameters:
- BUF_DEPTH, 16, beats the R buffer holds; must be >= 1.
- MAX_TXNS, 8, max admitted bursts not yet fully drained; must be >= 1.
- CNT_W, $clog2(BUF_DEPTH+1), derived, do not override; width of credit count.
- TXN_W, $clog2(MAX_TXNS+1), derived, do not override; width of txn count.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_ni  in  1  reset; synchronous, active-low.
- slv_ar_valid_i  in  1  upstream AR valid.
- slv_ar_len_i  in  8  upstream AR len (beats-1), axi len_t.
- slv_ar_ready_o  out  1  upstream AR ready.
- mst_ar_valid_o  out  1  downstream AR valid.
- mst_ar_ready_i  in  1  downstream AR ready.
- r_pop_i  in  1  one beat left the buffer (slv_r_valid & slv_r_ready).
- r_pop_last_i  in  1  popped beat has r_last set; qualified by r_pop_i.
- free_o  out  CNT_W  unreserved buffer beats.
- txns_o  out  TXN_W  admitted bursts whose last beat is not yet popped.
- oversize_o  out  1  high while an oversize burst is admitted or in flight.

Behaviour:
- Reset (rst_ni=0 at a clock edge):
  - state=IDLE, free_q=BUF_DEPTH, txns_q=0, ovs_q=0.
  - Outputs: mst_ar_valid_o=0, slv_ar_ready_o=0, free_o=BUF_DEPTH, txns_o=0, oversize_o=0.
  - Reset mid-burst discards all reservations. The surrounding buffer is reset together with this block.
- need = slv_ar_len_i + 1, computed 9 bits wide. Oversize when need > BUF_DEPTH.
- Normal admit condition: slv_ar_valid_i & !ovs_q & txns_q < MAX_TXNS & need <= free_q & !oversize.
- Oversize admit condition: slv_ar_valid_i & oversize & !ovs_q & txns_q==0 & free_q==BUF_DEPTH.
- FSM has two states:
  - IDLE:
    - mst_ar_valid_o=0, slv_ar_ready_o=0.
    - On a normal admit: free_q -= need, txns_q += 1, go ISSUE.
    - On an oversize admit: free_q = 0, txns_q = 1, ovs_q = 1, go ISSUE.
  - ISSUE:
    - mst_ar_valid_o=1 (registered), held until handshake.
    - slv_ar_ready_o = mst_ar_ready_i, combinational.
    - On mst_ar_ready_i: go IDLE. Issue takes a 1-cycle minimum, so back-to-back ARs are issued every 2 cycles.
- Latency: slv_ar_valid_i and the admit condition true in cycle N -> mst_ar_valid_o=1 in cycle N+1. No combinational valid path.
- AXI stability:
  - mst_ar_valid_o never drops before handshake.
  - Upstream AR fields must be held stable by the upstream until slv_ar_ready_o, per AXI. The block relies on this.
  - Because of that, len is sampled only at admission.
- Credit return:
  - Each r_pop_i with !ovs_q: free_q += 1.
  - r_pop_i & r_pop_last_i: txns_q -= 1.
- Simultaneous reserve and pop in the same cycle: free_q_next = free_q - need + r_pop_i. txns_q_next = txns_q + 1 - (r_pop_i & r_pop_last_i). Both counters are updated in a single assignment, never with last-write-wins.
- Oversize burst:
  - While ovs_q, pops do not touch free_q. There are no further admissions.
  - On a pop with last, while ovs_q: free_q=BUF_DEPTH, txns_q=0, ovs_q=0.
  - oversize_o=ovs_q.
  - The buffer may back-pressure during an oversize burst. This is accepted and documented.
- Bounds:
  - free_q never exceeds BUF_DEPTH and never underflows.
  - txns_q never exceeds MAX_TXNS.
  - A pop with txns_q==0, or a pop beyond the reservation, is a protocol error. Simulation assertion only; no RTL recovery.
- Elaboration assertions: BUF_DEPTH>=1, MAX_TXNS>=1.

Test Plan:
- Basic admit: BUF_DEPTH=16, AR len=3, mst_ar_ready_i=1 -> mst_ar_valid_o rises 1 cycle later, handshake next cycle. free_o 16->12, txns_o=1. After 4 pops, last on the 4th -> free_o=16, txns_o=0.
- Insufficient credits: admit len=11 (free 4), then present len=7 -> no mst_ar_valid_o. After 4 pops -> free=8 -> admitted next cycle, free_o=0.
- Simultaneous reserve and pop: free=5, admit len=4 in the same cycle as r_pop_i=1 (not last) -> free_o=1, txns_o=2.
- Txn limit: MAX_TXNS=2, three len=0 ARs -> third waits until a pop with last, then issues. txns_o never exceeds 2.
- Oversize: len=31 with BUF_DEPTH=16 and an empty buffer -> admitted, oversize_o=1, free_o=0. A len=0 AR is blocked for all 32 pops. After the last pop -> free_o=16, oversize_o=0, len=0 admitted.
- Downstream stall plus reset: mst_ar_ready_i=0 for 5 cycles -> mst_ar_valid_o held, slv_ar_ready_o=0. rst_ni=0 for one edge mid-stall -> valid=0, free_o=16, txns_o=0 next cycle.
